// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

    localparam int SERIAL_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_full_add.sv
// One-bit full adder used as the serial subtractor's arithmetic cell.
// Port names match the existing library cell.
module full_add (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b via a + ~b + 1, LSB first.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             sum, cout, last, accept;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept = start && (state_q != RUN);

    full_add u_fa (
        .A    (a_q[0]),
        .B    (~b_q[0]),
        .Cin  (carry_q),
        .Sum  (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Results are only published on the final bit, never mid-run.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            cnt_d   = '0;
            carry_d = 1'b1;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {sum, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            carry_d = cout;
            if (last) begin
                diff_d   = res_d;
                borrow_d = ~cout;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d    = (a_q[0] != b_q[0]) && (sum != a_q[0]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  single-cycle pulse marking a valid result.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 borrow  output  1  high when unsigned a < b.
REQ-011 ovf  output  1  signed two's-complement overflow; present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 The block SHALL compute a - b bit-serially, LSB first, as a + ~b + 1, one bit per clock, through a single 1-bit full adder.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE -> RUN when start=1: capture a and b, carry := 1, bit counter := 0, busy := 1.
REQ-015 In RUN, each edge SHALL shift in one sum bit and update the carry; after bit WIDTH-1 the state SHALL go to DONE.
REQ-016 Latency: done SHALL be high exactly WIDTH edges after the edge that accepted start, for one cycle only.
REQ-017 On the edge entering DONE: busy := 0, done := 1, diff = full result, borrow = ~final carry.
REQ-018 DONE -> IDLE on the next edge with start=0; DONE -> RUN with start=1, capturing new operands (back-to-back, no idle bubble).
REQ-019 start while busy=1 SHALL be ignored; operands in flight SHALL remain unaffected.
REQ-020 diff, borrow and ovf SHALL hold their last values until the next DONE entry; they SHALL NOT show partial results during RUN.
REQ-021 Operand changes on a and b outside the accepting edge SHALL have no effect.

Reset
REQ-022 On rst=1 at a rising edge: state := IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, counter and carry cleared.
REQ-023 rst SHALL take priority over start; rst during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-024 With SERIAL_SUB_OVF_EN defined, port ovf SHALL exist and equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), updated on DONE entry.
REQ-025 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-027 The per-bit arithmetic SHALL be one instance of the existing full_add (ports A, B, Cin, Sum, Cout); Cout SHALL feed the carry register.
REQ-028 The counter SHALL be sized ceil(log2(WIDTH))+1 bits; operand and result storage SHALL be shift registers.

Verification (WIDTH=8)
REQ-029 Basic: a=0x05, b=0x03, start -> done after 8 edges; diff=0x02, borrow=0, ovf=0.
REQ-030 Underflow: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0.
REQ-031 Signed overflow (OVF_EN build): a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
REQ-032 Ignore and back-to-back: start with a=0x10, b=0x01, re-pulse start at edge 3 with a=0xFF -> result 0x0F; start held during the done cycle with a=0x00, b=0x00 -> second done after 8 more edges, diff=0x00, borrow=0.
REQ-033 Reset mid-op: rst at edge 4 of RUN -> no done pulse, all outputs 0, busy=0; next start runs normally.
REQ-034 Exhaustive sweep at WIDTH=4: all 256 (a, b) pairs checked against a reference model for diff, borrow and ovf.
